// File: rtl/frac_pkg.sv
// Shared constants and encodings for the fractional-search block feeder.
package frac_pkg;

  localparam int ROWS   = 8;
  localparam int ROW_W  = 64;
  localparam int PIX_W  = 8;
  localparam int ROW_CW = $clog2(ROWS);

  // Lifecycle of one ping-pong bank.
  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Read-side sequencer.
  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_GAP    = 2'd2
  } rd_state_t;

endpackage

// File: rtl/frac_block_feeder_if.sv
// Row-pair input handshake plus the row stream toward the search stage.
interface frac_block_feeder_if;
  import frac_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ROW_W-1:0]  in_cur;
  logic [ROW_W-1:0]  in_ref;
  logic [ROW_W-1:0]  filter_pix;
  logic [ROW_W-1:0]  ref_pix;
  logic              input_ready;
  logic              out_valid;
  logic [ROW_CW-1:0] out_row;
  logic              busy;

  // The feeder itself.
  modport slave (
    input  in_valid, in_cur, in_ref,
    output in_ready, filter_pix, ref_pix, input_ready, out_valid, out_row, busy
  );

  // Whoever drives rows in and watches the stream.
  modport master (
    output in_valid, in_cur, in_ref,
    input  in_ready, filter_pix, ref_pix, input_ready, out_valid, out_row, busy
  );

endinterface

// File: rtl/frac_row_bank.sv
// Two-bank row store: one write port, one combinational read port.
// Entries hold {ref_row, cur_row}. No reset: a bank is only streamed after
// all of its rows have been rewritten, so stale contents are never observed.
module frac_row_bank
  import frac_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic                wr_bank,
  input  logic [ROW_CW-1:0]   wr_row,
  input  logic [2*ROW_W-1:0]  wr_data,
  input  logic                rd_bank,
  input  logic [ROW_CW-1:0]   rd_row,
  output logic [2*ROW_W-1:0]  rd_data
);

  logic [2*ROW_W-1:0] mem [2*ROWS];

  // Store an accepted row pair at {bank,row}.
  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_row}] <= wr_data;
  end

  assign rd_data = mem[{rd_bank, rd_row}];

endmodule

// File: rtl/frac_block_feeder.sv
// Ping-pong block feeder: loads 8x8 current/reference blocks one row per beat
// and streams each completed block as ROWS registered rows, then idles for at
// least GAP cycles so the search stage can get back to IDLE.
module frac_block_feeder
  import frac_pkg::*;
#(
  parameter int GAP = 2
) (
  input logic                clk,
  input logic                reset,
  frac_block_feeder_if.slave bus
);

  localparam int GAP_CW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  logic [1:0]         bank_full;
  logic               wr_bank_reg;
  logic [ROW_CW-1:0]  wr_cnt_reg;
  logic               rd_bank_reg;
  rd_state_t          rd_st_reg, rd_st_next;
  logic [GAP_CW-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [ROW_W-1:0]   filter_pix_reg, filter_pix_next;
  logic [ROW_W-1:0]   ref_pix_reg, ref_pix_next;
  logic               input_ready_reg, input_ready_next;
  logic               out_valid_reg, out_valid_next;
  logic [ROW_CW-1:0]  out_row_reg, out_row_next;
  logic [ROW_CW-1:0]  rd_row;
  logic [2*ROW_W-1:0] rd_data;
  logic               in_ready, accept, wr_last;
  logic               stream_start, stream_end;

  assign in_ready     = ~bank_full[wr_bank_reg];
  assign accept       = bus.in_valid & in_ready;
  assign wr_last      = accept && (wr_cnt_reg == ROW_CW'(ROWS - 1));
  assign stream_start = (rd_st_reg == RD_IDLE) && bank_full[rd_bank_reg];
  assign stream_end   = (rd_st_reg == RD_STREAM) && (out_row_reg == ROW_CW'(ROWS - 1));
  // Row to fetch for the next cycle: row 0 on a start, else the following row.
  assign rd_row       = (rd_st_reg == RD_STREAM) ? out_row_reg + ROW_CW'(1) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      bank_state_t st_reg;
      // Walk one bank through EMPTY -> FILLING -> FULL -> EMPTY; the write
      // side never targets a FULL bank so the two updates cannot collide.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          st_reg <= BANK_EMPTY;
        end else if (stream_end && (rd_bank_reg == 1'(gi))) begin
          st_reg <= BANK_EMPTY;
        end else if (accept && (wr_bank_reg == 1'(gi))) begin
          st_reg <= wr_last ? BANK_FULL : BANK_FILLING;
        end
      end
      assign bank_full[gi] = (st_reg == BANK_FULL);
    end
  endgenerate

  // Write pointer: row counter within the block and the bank being filled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_reg  <= '0;
      wr_bank_reg <= 1'b0;
    end else if (accept) begin
      wr_cnt_reg <= wr_last ? '0 : wr_cnt_reg + ROW_CW'(1);
      if (wr_last) wr_bank_reg <= ~wr_bank_reg;
    end
  end

  frac_row_bank u_bank (
    .clk     (clk),
    .we      (accept),
    .wr_bank (wr_bank_reg),
    .wr_row  (wr_cnt_reg),
    .wr_data ({bus.in_ref, bus.in_cur}),
    .rd_bank (rd_bank_reg),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  // Read sequencer state, gap counter, read bank and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_st_reg       <= RD_IDLE;
      gap_cnt_reg     <= '0;
      rd_bank_reg     <= 1'b0;
      filter_pix_reg  <= '0;
      ref_pix_reg     <= '0;
      input_ready_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_row_reg     <= '0;
    end else begin
      rd_st_reg       <= rd_st_next;
      gap_cnt_reg     <= gap_cnt_next;
      if (stream_end) rd_bank_reg <= ~rd_bank_reg;
      filter_pix_reg  <= filter_pix_next;
      ref_pix_reg     <= ref_pix_next;
      input_ready_reg <= input_ready_next;
      out_valid_reg   <= out_valid_next;
      out_row_reg     <= out_row_next;
    end
  end

  // Next read state; the gap counter leaves GAP when its next value hits 0.
  always_comb begin
    rd_st_next   = rd_st_reg;
    gap_cnt_next = gap_cnt_reg;
    case (rd_st_reg)
      RD_IDLE: begin
        if (bank_full[rd_bank_reg]) rd_st_next = RD_STREAM;
      end
      RD_STREAM: begin
        if (stream_end) begin
          if (GAP == 0) begin
            rd_st_next = RD_IDLE;
          end else begin
            rd_st_next   = RD_GAP;
            gap_cnt_next = GAP_CW'(GAP);
          end
        end
      end
      RD_GAP: begin
        gap_cnt_next = gap_cnt_reg - GAP_CW'(1);
        if (gap_cnt_reg == GAP_CW'(1)) rd_st_next = RD_IDLE;
      end
      default: rd_st_next = RD_IDLE;
    endcase
  end

  // Next output row; everything is zeroed whenever no row is presented.
  always_comb begin
    filter_pix_next  = '0;
    ref_pix_next     = '0;
    input_ready_next = 1'b0;
    out_valid_next   = 1'b0;
    out_row_next     = '0;
    if (stream_start || ((rd_st_reg == RD_STREAM) && !stream_end)) begin
      filter_pix_next  = rd_data[ROW_W-1:0];
      ref_pix_next     = rd_data[2*ROW_W-1:ROW_W];
      input_ready_next = stream_start;
      out_valid_next   = 1'b1;
      out_row_next     = rd_row;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.filter_pix  = filter_pix_reg;
  assign bus.ref_pix     = ref_pix_reg;
  assign bus.input_ready = input_ready_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_row     = out_row_reg;
  assign bus.busy        = (|bank_full) | out_valid_reg;

endmodule

// File: tb/tb_frac_block_feeder.sv
// Bench for frac_block_feeder: three instances (GAP=2, 5, 0) share one
// stimulus sequence. A timestamp model predicts, per block, the edge its last
// row was accepted (E) and the edge its row 0 appears (S), and derives every
// output and in_ready from those times.
module tb_frac_block_feeder;

  localparam int ND = 3;
  localparam int MAXB = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        drv_valid [ND];
  logic [63:0] drv_cur   [ND];
  logic [63:0] drv_ref   [ND];
  logic        obs_ready [ND];
  logic        obs_ir    [ND];
  logic        obs_ov    [ND];
  logic        obs_busy  [ND];
  logic [63:0] obs_fp    [ND];
  logic [63:0] obs_rp    [ND];
  logic [2:0]  obs_row   [ND];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      frac_block_feeder_if bus ();
      assign bus.in_valid = drv_valid[gi];
      assign bus.in_cur   = drv_cur[gi];
      assign bus.in_ref   = drv_ref[gi];
      assign obs_ready[gi] = bus.in_ready;
      assign obs_ir[gi]    = bus.input_ready;
      assign obs_ov[gi]    = bus.out_valid;
      assign obs_busy[gi]  = bus.busy;
      assign obs_fp[gi]    = bus.filter_pix;
      assign obs_rp[gi]    = bus.ref_pix;
      assign obs_row[gi]   = bus.out_row;
      frac_block_feeder #(.GAP(gi == 0 ? 2 : (gi == 1 ? 5 : 0))) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;      // 0: no beats, 1: valid always, 2: valid 50%
  int want = 0;      // blocks to load since the last reset
  bit pattern = 1'b0;

  int          nblk     [ND];
  int          first_blk[ND];
  int          wr_row   [ND];
  bit          hold     [ND];
  bit          exp_rdy  [ND];
  int          e_edge   [ND][MAXB];
  int          s_edge   [ND][MAXB];
  logic [63:0] m_cur    [ND][MAXB][8];
  logic [63:0] m_ref    [ND][MAXB][8];

  function automatic int gap_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 5 : 0);
  endfunction

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, d, cyc, obs, exp);
    end
  endtask

  // Block whose rows are on the output after edge t, or -1.
  function automatic int active_blk(input int d, input int t);
    for (int k = first_blk[d]; k < nblk[d]; k++)
      if (t >= s_edge[d][k] && t <= s_edge[d][k] + 7) return k;
    return -1;
  endfunction

  // A bank is FULL from its last accept until its last row has been shown.
  function automatic bit any_full(input int d, input int t);
    for (int k = first_blk[d]; k < nblk[d]; k++)
      if (t >= e_edge[d][k] && t <= s_edge[d][k] + 7) return 1'b1;
    return 1'b0;
  endfunction

  // The block being written shares its bank with the block two earlier.
  function automatic bit model_ready(input int d, input int t);
    int k;
    k = nblk[d];
    if (k - 2 >= first_blk[d] && t <= s_edge[d][k-2] + 7) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_dut(input int d);
    int k;
    int r;
    k = active_blk(d, cyc);
    if (k >= 0) begin
      r = cyc - s_edge[d][k];
      chk("out_valid", d, 64'(obs_ov[d]), 64'd1);
      chk("input_ready", d, 64'(obs_ir[d]), 64'(r == 0));
      chk("out_row", d, 64'(obs_row[d]), 64'(r));
      chk("filter_pix", d, obs_fp[d], m_cur[d][k][r]);
      chk("ref_pix", d, obs_rp[d], m_ref[d][k][r]);
    end else begin
      chk("out_valid", d, 64'(obs_ov[d]), 64'd0);
      chk("input_ready", d, 64'(obs_ir[d]), 64'd0);
      chk("out_row", d, 64'(obs_row[d]), 64'd0);
      chk("filter_pix", d, obs_fp[d], 64'd0);
      chk("ref_pix", d, obs_rp[d], 64'd0);
    end
    chk("busy", d, 64'(obs_busy[d]), 64'(any_full(d, cyc)));
    exp_rdy[d] = model_ready(d, cyc);
    chk("in_ready", d, 64'(obs_ready[d]), 64'(exp_rdy[d]));
  endtask

  task automatic drive_dut(input int d);
    logic [7:0] b;
    bit present;
    if (!hold[d]) begin
      present = (nblk[d] - first_blk[d] < want) &&
                (mode == 1 || (mode == 2 && $urandom_range(1) == 1));
      drv_valid[d] = present;
      if (pattern) begin
        b = 8'(wr_row[d]);
        drv_cur[d] = {8{b}};
      end else begin
        drv_cur[d] = {$urandom(), $urandom()};
      end
      drv_ref[d] = pattern ? ~drv_cur[d] : {$urandom(), $urandom()};
    end
  endtask

  task automatic accept_dut(input int d);
    int k;
    int s;
    k = nblk[d];
    m_cur[d][k][wr_row[d]] = drv_cur[d];
    m_ref[d][k][wr_row[d]] = drv_ref[d];
    if (wr_row[d] == 7) begin
      s = cyc + 1;
      if (k > first_blk[d] && s_edge[d][k-1] + 9 + gap_of(d) > s)
        s = s_edge[d][k-1] + 9 + gap_of(d);
      e_edge[d][k] = cyc;
      s_edge[d][k] = s;
      nblk[d]   = k + 1;
      wr_row[d] = 0;
    end else begin
      wr_row[d] = wr_row[d] + 1;
    end
  endtask

  // One clock: check state after edge cyc, drive, take edge cyc+1.
  task automatic step();
    for (int d = 0; d < ND; d++) check_dut(d);
    for (int d = 0; d < ND; d++) drive_dut(d);
    @(posedge clk);
    cyc++;
    for (int d = 0; d < ND; d++) begin
      if (drv_valid[d] && exp_rdy[d]) begin
        accept_dut(d);
        hold[d] = 1'b0;
      end else begin
        hold[d] = drv_valid[d];
      end
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk({tag, "_filter_pix"}, d, obs_fp[d], 64'd0);
      chk({tag, "_ref_pix"}, d, obs_rp[d], 64'd0);
      chk({tag, "_input_ready"}, d, 64'(obs_ir[d]), 64'd0);
      chk({tag, "_out_valid"}, d, 64'(obs_ov[d]), 64'd0);
      chk({tag, "_out_row"}, d, 64'(obs_row[d]), 64'd0);
      chk({tag, "_busy"}, d, 64'(obs_busy[d]), 64'd0);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      first_blk[d] = nblk[d];
      wr_row[d]    = 0;
      hold[d]      = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic do_reset();
    for (int d = 0; d < ND; d++) drv_valid[d] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      drv_valid[d] = 1'b0;
      drv_cur[d]   = '0;
      drv_ref[d]   = '0;
      nblk[d]      = 0;
      first_blk[d] = 0;
      wr_row[d]    = 0;
      hold[d]      = 1'b0;
      exp_rdy[d]   = 1'b1;
    end

    // Directed: one block of row-index bytes, ref = ~cur.
    do_reset();
    pattern = 1'b1;
    mode = 1;
    want = 1;
    repeat (20) step();

    // Three more blocks with in_valid held high; banks fill, in_ready drops.
    pattern = 1'b0;
    want = 4;
    repeat (90) step();

    // Random 50% valid, upstream holds a beat until it is taken.
    mode = 2;
    want = 11;
    repeat (240) step();
    mode = 0;
    repeat (30) step();

    // Asynchronous reset while row 4 streams and the other bank is half full.
    do_reset();
    mode = 1;
    want = 2;
    repeat (13) step();
    chk("pre_reset_out_row", 0, 64'(obs_row[0]), 64'd4);
    #2;
    for (int d = 0; d < ND; d++) drv_valid[d] = 1'b0;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Fresh blocks after reset; stale rows must not reappear.
    want = 2;
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
